// File: rtl/audio_clk_pkg.sv
// ============================================================================
// Module      : audio_clk_pkg
// Description : Shared types and width helpers for the audio clock generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_clk_pkg;

    localparam int c_state_w = 2;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2,
        ST_RETUNE = 2'd3
    } clk_state_e;

    // 12.288 MHz mclk tick from a 50 MHz refclk with a 32-bit accumulator
    localparam int unsigned c_inc_default = 32'd1055531163;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_clk_phase_acc.sv
// ============================================================================
// Module      : audio_clk_phase_acc
// Description : Phase accumulator producing the mclk tick from its carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_clk_phase_acc
    import audio_clk_pkg::*;
#(
    parameter int          ACC_WIDTH   = 32,
    parameter int unsigned INC_DEFAULT = c_inc_default
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_run,
    input  logic                 i_load_en,
    input  logic [ACC_WIDTH-1:0] i_load_val,
    output logic                 o_mclk_tick
);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_inc;
    logic                 r_mclk_tick;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_carry;

    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_mclk_tick <= 1'b0;
        end else if (i_run) begin
            r_acc       <= w_sum;
            r_mclk_tick <= w_carry;
        end else begin
            r_acc       <= '0;
            r_mclk_tick <= 1'b0;
        end
    end

    // The increment survives IDLE so a retune made while stopped is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inc <= ACC_WIDTH'(INC_DEFAULT);
        end else if (i_load_en) begin
            r_inc <= i_load_val;
        end
    end

    assign o_mclk_tick = r_mclk_tick;

endmodule

`default_nettype wire

// File: rtl/audio_clk_gen.sv
// ============================================================================
// Module      : audio_clk_gen
// Description : NCO-based I2S/TDM clock generator with lock tracking and
//               frame-aligned retuning.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_clk_gen
    import audio_clk_pkg::*;
#(
    parameter int          ACC_WIDTH   = 32,
    parameter int unsigned INC_DEFAULT = c_inc_default,
    parameter int          BCLK_DIV    = 4,
    parameter int          SLOT_BITS   = 32,
    parameter int          NUM_SLOTS   = 2,
    parameter int          LOCK_FRAMES = 4,
    localparam int         c_slot_w    = clog2_min1(NUM_SLOTS)
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic                 mclk_tick,
    output logic                 bclk_tick,
    output logic                 frame_start,
    output logic                 bclk,
    output logic                 lrck,
    output logic [c_slot_w-1:0]  slot_idx,
    output logic                 locked
);

    localparam int c_div_w = clog2_min1(BCLK_DIV);
    localparam int c_bit_w = clog2_min1(SLOT_BITS);
    localparam int c_frm_w = clog2_min1(LOCK_FRAMES);

    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_div_w-1:0]  c_div_half  = c_div_w'(BCLK_DIV / 2);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(SLOT_BITS - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(NUM_SLOTS - 1);
    localparam logic [c_frm_w-1:0]  c_frm_last  = c_frm_w'(LOCK_FRAMES - 1);

    clk_state_e           r_state;
    clk_state_e           w_state_next;
    logic [ACC_WIDTH-1:0] r_pending;
    logic [c_frm_w-1:0]   r_frame_cnt;

    logic [c_div_w-1:0]   r_div_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [c_slot_w-1:0]  r_slot;
    logic                 r_bclk_tick;
    logic                 r_bclk;
    logic                 r_lrck;
    logic                 r_frame_start;

    logic [c_div_w-1:0]   w_div_next;
    logic [c_bit_w-1:0]   w_bit_next;
    logic [c_slot_w-1:0]  w_slot_next;
    logic                 w_bclk_tick_next;
    logic                 w_bclk_next;
    logic                 w_frame_start_next;

    logic                 w_mclk_tick;
    logic                 w_run;
    logic                 w_accept;
    logic                 w_load_en;
    logic [ACC_WIDTH-1:0] w_load_val;

    assign w_run    = (r_state != ST_IDLE) && enable;
    assign w_accept = cfg_valid && (r_state != ST_RETUNE) && (cfg_inc != '0);

    audio_clk_phase_acc #(
        .ACC_WIDTH   (ACC_WIDTH),
        .INC_DEFAULT (INC_DEFAULT)
    ) u_phase_acc (
        .clk         (refclk),
        .rst         (rst),
        .i_run       (w_run),
        .i_load_en   (w_load_en),
        .i_load_val  (w_load_val),
        .o_mclk_tick (w_mclk_tick)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_SETTLE;
                ST_SETTLE: begin
                    if (w_accept) begin
                        w_state_next = ST_RETUNE;
                    end else if (r_frame_start && (r_frame_cnt == c_frm_last)) begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        w_state_next = ST_RETUNE;
                    end
                end
                ST_RETUNE: begin
                    if (r_frame_start) begin
                        w_state_next = ST_SETTLE;
                    end
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // A retune accepted while stopped (or while stopping) takes effect at once.
    always_comb begin
        cfg_ready  = (r_state != ST_RETUNE);
        locked     = (r_state == ST_LOCKED);
        w_load_en  = 1'b0;
        w_load_val = r_pending;
        if (w_accept && ((r_state == ST_IDLE) || !enable)) begin
            w_load_en  = 1'b1;
            w_load_val = cfg_inc;
        end else if ((r_state == ST_RETUNE) && (!enable || r_frame_start)) begin
            w_load_en  = 1'b1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (w_accept && (r_state != ST_IDLE)) begin
            r_pending <= cfg_inc;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (r_state != ST_SETTLE) begin
            r_frame_cnt <= '0;
        end else if (r_frame_start) begin
            r_frame_cnt <= r_frame_cnt + c_frm_w'(1);
        end
    end

    // ------------------------------------------------------ timing counters
    always_comb begin
        w_div_next         = r_div_cnt;
        w_bclk_tick_next   = 1'b0;
        w_bclk_next        = r_bclk;
        w_bit_next         = r_bit_cnt;
        w_slot_next        = r_slot;
        w_frame_start_next = 1'b0;
        if (!w_run) begin
            w_div_next  = '0;
            w_bclk_next = 1'b0;
            w_bit_next  = '0;
            w_slot_next = '0;
        end else begin
            if (w_mclk_tick) begin
                if (r_div_cnt == c_div_last) begin
                    w_div_next       = '0;
                    w_bclk_tick_next = 1'b1;
                    w_bclk_next      = 1'b1;
                end else begin
                    w_div_next = r_div_cnt + c_div_w'(1);
                    if (w_div_next == c_div_half) begin
                        w_bclk_next = 1'b0;
                    end
                end
            end
            if (r_bclk_tick) begin
                if (r_bit_cnt == c_bit_last) begin
                    w_bit_next = '0;
                    if (r_slot == c_slot_last) begin
                        w_slot_next        = '0;
                        w_frame_start_next = 1'b1;
                    end else begin
                        w_slot_next = r_slot + c_slot_w'(1);
                    end
                end else begin
                    w_bit_next = r_bit_cnt + c_bit_w'(1);
                end
            end
        end
    end

    // lrck follows enable so it is already high on the first running cycle.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_bclk_tick   <= 1'b0;
            r_bclk        <= 1'b0;
            r_bit_cnt     <= '0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
            r_lrck        <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_next;
            r_bclk_tick   <= w_bclk_tick_next;
            r_bclk        <= w_bclk_next;
            r_bit_cnt     <= w_bit_next;
            r_slot        <= w_slot_next;
            r_frame_start <= w_frame_start_next;
            r_lrck        <= enable && (w_slot_next == '0);
        end
    end

    assign mclk_tick   = w_mclk_tick;
    assign bclk_tick   = r_bclk_tick;
    assign bclk        = r_bclk;
    assign frame_start = r_frame_start;
    assign lrck        = r_lrck;
    assign slot_idx    = r_slot;

endmodule

`default_nettype wire
